// File: rtl/hbt_update_ctrl.sv
// Arbitrates the single history-table port between zero-latency fetch lookups and an in-order update FIFO.
// Updates drain when fetch is idle; a full FIFO forces a drain and raises ctrl_stall until it is no longer full.
module hbt_update_ctrl #(
  parameter int SIZE  = 200,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fetch_pc,
  input  logic        fetch_stall,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic [15:0] res_target,
  input  logic        res_taken,
  output logic [15:0] hbt_addr,
  output logic [15:0] hbt_datain,
  output logic        hbt_w,
  output logic        hbt_hbin,
  input  logic [15:0] hbt_dataout,
  input  logic        hbt_hbout,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  output logic        ctrl_stall,
  output logic [2:0]  fifo_count
);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]      FULL_CNT = 3'(DEPTH);
  localparam logic [15:0]     SIZE_PC  = 16'(SIZE);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] target;
    logic        taken;
  } upd_t;

  upd_t          mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          push, pop, full;
  upd_t          head;
  upd_t          fwd_ent;
  logic          fwd_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full = (count_q == FULL_CNT);
  assign head = mem_q[rd_ptr_q];
  assign push = res_valid && (res_pc < SIZE_PC);
  assign pop  = !reset && (count_q != 3'd0) && (fetch_stall || full);

  // Walk oldest to youngest so the last match left standing is the youngest entry.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit = 1'b0;
    fwd_ent = '0;
    idx     = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((3'(i) < count_q) && (mem_q[idx].pc == fetch_pc)) begin
        fwd_hit = 1'b1;
        fwd_ent = mem_q[idx];
      end
      idx = ptr_inc(idx);
    end
  end

  always_comb begin
    hbt_addr    = fetch_pc;
    hbt_datain  = '0;
    hbt_hbin    = 1'b0;
    hbt_w       = 1'b0;
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (pop) begin
      hbt_addr   = head.pc;
      hbt_datain = head.target;
      hbt_hbin   = head.taken;
      hbt_w      = 1'b1;
    end else if (!reset && !fetch_stall) begin
      pred_valid = 1'b1;
      if (fwd_hit) begin
        pred_taken  = fwd_ent.taken;
        pred_target = fwd_ent.target;
      end else if (fetch_pc < SIZE_PC) begin
        pred_taken  = hbt_hbout;
        pred_target = hbt_dataout;
      end
    end
  end

  assign ctrl_stall = !reset && full;
  assign fifo_count = reset ? 3'd0 : count_q;

  // A push while full is always paired with a pop, so count never exceeds DEPTH.
  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{pc: res_pc, target: res_target, taken: res_taken};
      end
    end
  end

endmodule

// File: tb/tb_hbt_update_ctrl.sv
// Randomized and directed bench for hbt_update_ctrl with a queue-based reference model and scoreboard.
module tb_hbt_update_ctrl;
  localparam int SIZE  = 200;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] fetch_pc;
  logic        fetch_stall;
  logic        res_valid;
  logic [15:0] res_pc;
  logic [15:0] res_target;
  logic        res_taken;
  logic [15:0] hbt_addr;
  logic [15:0] hbt_datain;
  logic        hbt_w;
  logic        hbt_hbin;
  logic [15:0] hbt_dataout;
  logic        hbt_hbout;
  logic        pred_valid;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        ctrl_stall;
  logic [2:0]  fifo_count;

  hbt_update_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .res_valid(res_valid), .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
    .hbt_addr(hbt_addr), .hbt_datain(hbt_datain), .hbt_w(hbt_w), .hbt_hbin(hbt_hbin),
    .hbt_dataout(hbt_dataout), .hbt_hbout(hbt_hbout),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .ctrl_stall(ctrl_stall), .fifo_count(fifo_count)
  );

  // Environment table that the DUT actually reads and writes.
  logic [15:0] mem_tgt [0:65535];
  logic        mem_tk  [0:65535];
  assign hbt_dataout = mem_tgt[hbt_addr];
  assign hbt_hbout   = mem_tk[hbt_addr];

  // Reference model state: the table as it should look, plus pending updates in arrival order.
  logic [15:0] ref_tgt [0:65535];
  logic        ref_tk  [0:65535];
  typedef struct {
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        tk;
  } ent_t;
  ent_t pend[$];

  typedef struct packed {
    logic        rst;
    logic [15:0] addr;
    logic [15:0] din;
    logic        w;
    logic        hbin;
    logic        pv;
    logic        pt;
    logic [15:0] ptgt;
    logic        cs;
    logic [2:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fifo_count", 32'(fifo_count), 32'(e.cnt));
        chk("hbt_w", 32'(hbt_w), 32'(e.w));
        chk("ctrl_stall", 32'(ctrl_stall), 32'(e.cs));
        chk("pred_valid", 32'(pred_valid), 32'(e.pv));
        if (!e.rst) begin
          chk("hbt_addr", 32'(hbt_addr), 32'(e.addr));
          chk("hbt_datain", 32'(hbt_datain), 32'(e.din));
          chk("hbt_hbin", 32'(hbt_hbin), 32'(e.hbin));
          if (e.pv) begin
            chk("pred_taken", 32'(pred_taken), 32'(e.pt));
            chk("pred_target", 32'(pred_target), 32'(e.ptgt));
          end
        end
      end
    end
  end

  // One clock of stimulus; called right after a falling edge, returns at the next falling edge.
  task automatic step(input logic r, input logic [15:0] fpc, input logic fst,
                      input logic rv, input logic [15:0] rpc, input logic [15:0] rtgt, input logic rtk);
    exp_t e;
    bit   drain;
    bit   found;
    int   n;
    reset = r; fetch_pc = fpc; fetch_stall = fst;
    res_valid = rv; res_pc = rpc; res_target = rtgt; res_taken = rtk;
    n     = pend.size();
    drain = !r && (n > 0) && (fst || n == DEPTH);
    e      = '0;
    e.rst  = r;
    e.cnt  = r ? 3'd0 : 3'(n);
    e.cs   = !r && (n == DEPTH);
    if (drain) begin
      e.w    = 1'b1;
      e.addr = pend[0].pc;
      e.din  = pend[0].tgt;
      e.hbin = pend[0].tk;
    end else begin
      e.addr = fpc;
      e.pv   = !r && !fst;
      if (e.pv) begin
        found = 1'b0;
        for (int k = n - 1; k >= 0 && !found; k--) begin
          if (pend[k].pc == fpc) begin
            found  = 1'b1;
            e.pt   = pend[k].tk;
            e.ptgt = pend[k].tgt;
          end
        end
        if (!found && fpc < 16'(SIZE)) begin
          e.pt   = ref_tk[fpc];
          e.ptgt = ref_tgt[fpc];
        end
      end
    end
    #2;
    exp_q.push_back(e);
    #2;
    if (hbt_w) begin
      mem_tgt[hbt_addr] = hbt_datain;
      mem_tk[hbt_addr]  = hbt_hbin;
    end
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
    end else begin
      if (drain) begin
        ref_tgt[pend[0].pc] = pend[0].tgt;
        ref_tk[pend[0].pc]  = pend[0].tk;
        void'(pend.pop_front());
      end
      if (rv && rpc < 16'(SIZE)) pend.push_back('{pc: rpc, tgt: rtgt, tk: rtk});
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_pc();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 70)      return 16'($urandom_range(0, 15));
    else if (sel < 85) return 16'($urandom_range(SIZE - 3, SIZE + 60));
    else               return 16'($urandom_range(0, SIZE - 1));
  endfunction

  initial begin
    int mism;
    for (int i = 0; i < 512; i++) begin
      mem_tgt[i] = 16'($urandom);
      mem_tk[i]  = 1'($urandom);
      ref_tgt[i] = mem_tgt[i];
      ref_tk[i]  = mem_tk[i];
    end
    mem_tgt[5] = 16'h0040; mem_tk[5] = 1'b1;
    ref_tgt[5] = 16'h0040; ref_tk[5] = 1'b1;

    @(negedge clk);
    // Reset with a resolving branch present: it must be ignored.
    step(1, 16'd3, 0, 1, 16'd4, 16'h1111, 1);
    step(1, 16'd3, 0, 1, 16'd4, 16'h1111, 1);
    // Plain table lookup.
    step(0, 16'd5, 0, 0, 16'd0, 16'h0, 0);
    // Push then drain on a fetch stall.
    step(0, 16'd1, 0, 1, 16'd7, 16'h0010, 1);
    step(0, 16'd1, 1, 0, 16'd0, 16'h0, 0);
    step(0, 16'd7, 0, 0, 16'd0, 16'h0, 0);
    // Fill to DEPTH, then push during the forced drain.
    for (int i = 0; i < DEPTH; i++) step(0, 16'd2, 0, 1, 16'(20 + i), 16'(16'h0100 + i), 1'(i));
    step(0, 16'd21, 0, 1, 16'd30, 16'h0A0A, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 16'd2, 1, 0, 16'd0, 16'h0, 0);
    // Youngest-entry forwarding and same-cycle non-forwarding.
    step(0, 16'd9, 0, 1, 16'd9, 16'h0022, 1);
    step(0, 16'd9, 0, 1, 16'd9, 16'h0033, 0);
    step(0, 16'd9, 0, 0, 16'd0, 16'h0, 0);
    step(0, 16'd9, 1, 0, 16'd0, 16'h0, 0);
    step(0, 16'd9, 1, 0, 16'd0, 16'h0, 0);
    step(0, 16'd9, 0, 0, 16'd0, 16'h0, 0);
    // Out-of-range resolve and fetch.
    step(0, 16'd3, 0, 1, 16'd200, 16'h7777, 1);
    step(0, 16'd250, 0, 0, 16'd0, 16'h0, 0);
    step(0, 16'd199, 0, 1, 16'd199, 16'h0199, 1);
    step(0, 16'd199, 1, 0, 16'd0, 16'h0, 0);
    // Reset with three updates pending: they must never reach the table.
    for (int i = 0; i < 3; i++) step(0, 16'd4, 0, 1, 16'(40 + i), 16'hBEEF, 1);
    step(1, 16'd4, 1, 0, 16'd0, 16'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'(40 + i), 1, 0, 16'd0, 16'h0, 0);

    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, rand_pc(), ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, rand_pc(), 16'($urandom), 1'($urandom));
    end
    for (int c = 0; c < DEPTH + 1; c++) step(0, 16'd0, 1, 0, 16'd0, 16'h0, 0);

    #4;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (mem_tgt[i] !== ref_tgt[i] || mem_tk[i] !== ref_tk[i]) mism++;
    end
    chk("table_contents", 32'(mism), 32'd0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
